// File: rtl/hex_uart_dump.sv
// rtl/hex_uart_dump.sv - hex-dump UART transmitter with word FIFO and 8N1 serializer
//
// Buffers DATA_WIDTH-bit words and sends each one as uppercase ASCII hex,
// most significant nibble first, optionally followed by CR LF.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   word_valid producer offers word
//   word_ready FIFO has room (registered state only)
//   word       data word to dump
//   TxD        8N1 serial output, idle high
//   busy       FIFO non-empty or a character in flight
//   level      FIFO occupancy
module hex_uart_dump #(
  parameter int DATA_WIDTH   = 256,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int APPEND_CRLF  = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         word_valid,
  output logic                         word_ready,
  input  logic [DATA_WIDTH-1:0]        word,
  output logic                         TxD,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int BW      = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_CR, S_LF} state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // ---------------- FIFO ----------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  assign word_ready = (level != LW'(FIFO_DEPTH));
  assign push       = word_valid && word_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
    end
  end

  // ---------------- UART ----------------
  logic          tx_start_q;
  logic [7:0]    tx_byte_q;
  logic          tx_active;
  logic [3:0]    bit_idx;
  logic [BW-1:0] baud_cnt;
  logic [7:0]    tx_data;
  logic          tx_done;

  // Combinational done lets the FSM react on the very edge the stop bit ends,
  // which keeps the inter-character overhead at two cycles.
  assign tx_done = tx_active && (baud_cnt == BW'(CLKS_PER_BIT - 1)) && (bit_idx == 4'd9);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      TxD       <= 1'b1;
      tx_active <= 1'b0;
      bit_idx   <= '0;
      baud_cnt  <= '0;
      tx_data   <= '0;
    end else if (!tx_active) begin
      if (tx_start_q) begin
        tx_active <= 1'b1;
        baud_cnt  <= '0;
        bit_idx   <= '0;
        tx_data   <= tx_byte_q;
        TxD       <= 1'b0;
      end
    end else if (baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
      baud_cnt <= '0;
      if (bit_idx == 4'd9) begin
        tx_active <= 1'b0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        // bit_idx 0..7 moves onto data bit bit_idx; 8 moves onto the stop bit
        TxD     <= (bit_idx == 4'd8) ? 1'b1 : tx_data[bit_idx[2:0]];
      end
    end else begin
      baud_cnt <= baud_cnt + BW'(1);
    end
  end

  // ---------------- FSM ----------------
  state_t                state, state_n;
  logic [CW-1:0]         char_idx, char_idx_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  sent, sent_n;
  logic                  start_n;
  logic [7:0]            byte_n;
  logic                  fetch;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      char_idx   <= '0;
      shreg      <= '0;
      sent       <= 1'b0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state      <= state_n;
      char_idx   <= char_idx_n;
      shreg      <= shreg_n;
      sent       <= sent_n;
      tx_start_q <= start_n;
      tx_byte_q  <= byte_n;
    end
  end

  always_comb begin
    state_n    = state;
    char_idx_n = char_idx;
    shreg_n    = shreg;
    sent_n     = sent;
    start_n    = 1'b0;
    byte_n     = tx_byte_q;
    pop        = 1'b0;
    fetch      = 1'b0;
    case (state)
      S_IDLE: fetch = 1'b1;
      S_LOAD: begin
        start_n = 1'b1;
        byte_n  = hex_char(shreg[DATA_WIDTH-1 -: 4]);
        state_n = S_SEND;
      end
      S_SEND: begin
        if (tx_done) begin
          if (char_idx != CW'(NIBBLES - 1)) begin
            char_idx_n = char_idx + CW'(1);
            shreg_n    = shreg << 4;
            state_n    = S_LOAD;
          end else if (APPEND_CRLF != 0) begin
            sent_n  = 1'b0;
            state_n = S_CR;
          end else begin
            fetch = 1'b1;
          end
        end
      end
      S_CR: begin
        // sent marks that the start pulse went out; afterwards wait for done
        if (!sent) begin
          start_n = 1'b1;
          byte_n  = 8'h0D;
          sent_n  = 1'b1;
        end else if (tx_done) begin
          sent_n  = 1'b0;
          state_n = S_LF;
        end
      end
      S_LF: begin
        if (!sent) begin
          start_n = 1'b1;
          byte_n  = 8'h0A;
          sent_n  = 1'b1;
        end else if (tx_done) begin
          sent_n = 1'b0;
          fetch  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // End of a word acts as IDLE for one cycle: pop a backlogged word at once.
    if (fetch) begin
      if (level != '0) begin
        pop        = 1'b1;
        shreg_n    = mem[rd_ptr];
        char_idx_n = '0;
        state_n    = S_LOAD;
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  assign busy = (level != '0) || (state != S_IDLE);

endmodule

// File: doc/hex_uart_dump.md
# hex_uart_dump

Parametrised hex-dump UART transmitter: buffers DATA_WIDTH-bit words in an internal synchronous FIFO, then emits each word as uppercase ASCII hex (most significant nibble first), optionally followed by CR LF, on an integrated 8N1 UART.

- Runs entirely on one clock. Producer-to-UART clock crossing is handled upstream.
- Sits at the debug/telemetry output of the image-processing pipeline.
- Replaces the fixed 256-bit, fire-and-forget word dumper with valid/ready flow control, configurable width/depth/baud and line framing.

## Interface
Parameters:
- DATA_WIDTH, 256: input word width. Must be a multiple of 4, minimum 4. NIBBLES = DATA_WIDTH/4.
- FIFO_DEPTH, 4: words buffered. Power of two, at least 2.
- CLKS_PER_BIT, 868: clk cycles per UART bit. Must be at least 2.
- APPEND_CRLF, 1: 1 = send 0x0D then 0x0A after each word; 0 = hex characters only.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- word_valid  in  1  producer offers `word`
- word_ready  out  1  FIFO can accept; a transfer occurs on a rising edge where valid && ready
- word  in  DATA_WIDTH  data to dump
- TxD  out  1  UART serial output, idle high
- busy  out  1  high while the FIFO is non-empty or a character is in flight
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Reset values: TxD=1, word_ready=1, busy=0, level=0. FIFO pointers cleared, FSM in IDLE.
- Reset asserted mid-character aborts the character. TxD returns to 1 immediately (asynchronously), and queued words are discarded.
- FIFO:
  - word_ready = (level != FIFO_DEPTH), derived from registered state only. There is no combinational path from pop to ready.
  - A push and a pop in the same cycle leave level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - word_valid while word_ready=0 is ignored; the data is not stored.
- FSM states:
  - IDLE: if level != 0, pop the head word into the shift register, set char_idx=0, and go to LOAD.
  - LOAD: present byte = hex(nibble[char_idx]), start the UART, go to SEND.
  - SEND: wait for the UART done pulse, then:
    - if char_idx < NIBBLES-1: char_idx++, go to LOAD;
    - else if APPEND_CRLF: go to CR;
    - else go to IDLE.
  - CR: send 0x0D, wait for done, go to LF.
  - LF: send 0x0A, wait for done, go to IDLE.
- Nibble order: char_idx 0 = word[DATA_WIDTH-1 -: 4]; the last character = word[3:0].
- Hex map: values 0–9 map to 0x30–0x39; values 10–15 map to 0x41–0x46.
- UART frame:
  - start bit 0, then 8 data bits LSB first, then stop bit 1;
  - each bit held exactly CLKS_PER_BIT cycles;
  - the baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1, and wraps.
- busy = (level != 0) || (state != IDLE).

## Timing
- Empty-FIFO latency: word accepted at edge k; level=1 after edge k; pop at edge k+1; LOAD at edge k+2; TxD falls at edge k+3 (3-cycle start latency).
- Character period = 10*CLKS_PER_BIT cycles, plus 2 cycles of FSM overhead (SEND→LOAD→start) between consecutive characters. Any gap between characters is spent at TxD=1.
- Word period = (NIBBLES + 2*APPEND_CRLF) * (10*CLKS_PER_BIT + 2) cycles.
- With a backlog, IDLE pops the next word on the cycle it is entered. There is no extra idle gap beyond the 2-cycle overhead.
- Throughput limit: sustained word_valid faster than one word per word period fills the FIFO. word_ready then drops and no data is lost.

## Test plan
- Reset: rstn low for 3 cycles, then high. TxD=1, word_ready=1, busy=0 and level=0 until the first push.
- Single word (DATA_WIDTH=16, CLKS_PER_BIT=4, APPEND_CRLF=1): push 0xA5F0.
  - UART decoder receives 0x41, 0x35, 0x46, 0x30, 0x0D, 0x0A.
  - First TxD fall occurs 3 cycles after acceptance.
  - Each bit lasts 4 cycles.
  - busy falls after the LF stop bit.
- Full/back-pressure (FIFO_DEPTH=4): hold word_valid=1 with words 0x0001..0x0006.
  - word_ready falls at level=4.
  - Exactly words 1..6 are output in order; none are lost or duplicated.
  - level never exceeds 4.
- Simultaneous push/pop: at level=1, push on the same edge the FSM pops. level stays 1 and both words are output in order.
- No framing (APPEND_CRLF=0, DATA_WIDTH=8): push 0x9C. Output is exactly 0x39, 0x43, with no 0x0D/0x0A.
- Reset mid-operation: assert rstn during the 3rd data bit of the 2nd character with 2 words queued.
  - TxD=1 and level=0 immediately.
  - After release, a pushed 0x1234 is output cleanly as 0x31, 0x32, 0x33, 0x34, 0x0D, 0x0A.
